// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg -- shared types for the two-master memory arbiter.
// Holds the arbiter FSM state encoding, the master identifier type and the
// lock-counter width. Imported by mem_arbiter and mem_arbiter_rr.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOCK,
      COOL
   } state_t;

   typedef enum logic {
      M0 = 1'b0,
      M1 = 1'b1
   } master_id_t;

   localparam int unsigned LOCK_CNT_W = 8;

endpackage

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr -- two-input grant selector (purely combinational).
// Ports:
//   i_req0, i_req1 : eligible requests (already masked by the caller)
//   i_favour       : master that wins when both request
//   o_gnt0, o_gnt1 : one-hot (or zero) grant
// Fixed priority is obtained by tying i_favour to M0; round-robin by feeding
// it from a last-granted pointer held in the parent.
module mem_arbiter_rr
   import mem_arbiter_pkg::*;
(
   input  logic       i_req0,
   input  logic       i_req1,
   input  master_id_t i_favour,
   output logic       o_gnt0,
   output logic       o_gnt1
);

   always_comb begin
      o_gnt0 = i_req0 & ~(i_req1 & (i_favour == M1));
      o_gnt1 = i_req1 & ~(i_req0 & (i_favour == M0));
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- arbitrates two masters (m0 core LSU, m1 DMA/debug) onto one
// shared slave port with fixed one-cycle response latency.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   mN_req/we/be/addr/wdata : master N request channel (inputs)
//   mN_gnt_o                : combinational grant for this cycle
//   mN_rvalid_o/rdata_o     : response one cycle after grant
//   m1_lock_i               : m1 exclusive-ownership request
//   s_req/we/be/addr/wdata  : shared slave request (outputs)
//   s_rdata_i               : slave read data, one cycle after s_req_o
// Parameters: MAX_LOCK (1..255) consecutive LOCK grants to m1, ADDR_W.
// Build option: define MEM_ARBITER_RR_EN for round-robin IDLE tie-break;
// otherwise m0 has fixed priority.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned MAX_LOCK = 8,
   parameter int unsigned ADDR_W   = 32
)(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              m0_req_i,
   input  logic              m0_we_i,
   input  logic [3:0]        m0_be_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [31:0]       m0_wdata_i,
   output logic              m0_gnt_o,
   output logic              m0_rvalid_o,
   output logic [31:0]       m0_rdata_o,
   input  logic              m1_req_i,
   input  logic              m1_we_i,
   input  logic [3:0]        m1_be_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [31:0]       m1_wdata_i,
   output logic              m1_gnt_o,
   output logic              m1_rvalid_o,
   output logic [31:0]       m1_rdata_o,
   input  logic              m1_lock_i,
   output logic              s_req_o,
   output logic              s_we_o,
   output logic [3:0]        s_be_o,
   output logic [ADDR_W-1:0] s_addr_o,
   output logic [31:0]       s_wdata_o,
   input  logic [31:0]       s_rdata_i
);

   localparam logic [LOCK_CNT_W-1:0] MAX_CNT = LOCK_CNT_W'(MAX_LOCK);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [LOCK_CNT_W-1:0]   r_cnt;
   logic [LOCK_CNT_W-1:0]   w_cnt_nxt;
   logic                    r_pend0;
   logic                    r_pend1;
   logic                    w_req0;
   logic                    w_req1;
   logic                    w_gnt0;
   logic                    w_gnt1;
   master_id_t              w_favour;

   // m0 is locked out while m1 owns the port; nothing is granted in reset.
   assign w_req0 = m0_req_i & ~rst_i & (r_state != LOCK);
   assign w_req1 = m1_req_i & ~rst_i;

`ifdef MEM_ARBITER_RR_EN
   master_id_t r_last;

   always_ff @(posedge clk_i) begin
      if (rst_i)       r_last <= M1;
      else if (w_gnt0) r_last <= M0;
      else if (w_gnt1) r_last <= M1;
   end

   // COOL always favours m0; otherwise the last winner loses the tie.
   assign w_favour = ((r_state == COOL) || (r_last == M1)) ? M0 : M1;
`else
   assign w_favour = M0;
`endif

   mem_arbiter_rr u_sel (
      .i_req0   (w_req0),
      .i_req1   (w_req1),
      .i_favour (w_favour),
      .o_gnt0   (w_gnt0),
      .o_gnt1   (w_gnt1)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_gnt1 && m1_lock_i) begin
               w_state_nxt = LOCK;
               w_cnt_nxt   = '0;
            end
         end
         LOCK: begin
            if (!m1_lock_i) begin
               w_state_nxt = IDLE;
            end else if (w_gnt1) begin
               w_cnt_nxt = (r_cnt == MAX_CNT) ? r_cnt : r_cnt + 1'b1;
               if (w_cnt_nxt == MAX_CNT) w_state_nxt = COOL;
            end
         end
         COOL:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s_req_o   = w_gnt0 | w_gnt1;
      s_we_o    = 1'b0;
      s_be_o    = '0;
      s_addr_o  = '0;
      s_wdata_o = '0;
      if (w_gnt1) begin
         s_we_o    = m1_we_i;
         s_be_o    = m1_be_i;
         s_addr_o  = m1_addr_i;
         s_wdata_o = m1_wdata_i;
      end else if (w_gnt0) begin
         s_we_o    = m0_we_i;
         s_be_o    = m0_be_i;
         s_addr_o  = m0_addr_i;
         s_wdata_o = m0_wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pend0 <= 1'b0;
         r_pend1 <= 1'b0;
      end else begin
         r_pend0 <= w_gnt0;
         r_pend1 <= w_gnt1;
      end
   end

   // A response still pending when reset rises is suppressed immediately.
   assign m0_gnt_o    = w_gnt0;
   assign m1_gnt_o    = w_gnt1;
   assign m0_rvalid_o = r_pend0 & ~rst_i;
   assign m1_rvalid_o = r_pend1 & ~rst_i;
   assign m0_rdata_o  = m0_rvalid_o ? s_rdata_i : '0;
   assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- scoreboard bench for mem_arbiter (MAX_LOCK=4).
// Expected grants/responses are queued when stimulus is applied; a negedge
// monitor pops and compares whenever the DUT grants or returns a response.
// Expectations follow MEM_ARBITER_RR_EN when that macro is defined.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } stim_t;

   typedef struct {
      int    cyc;
      logic  id;
      stim_t s;
   } gexp_t;

   typedef struct {
      int          cyc;
      logic        id;
      logic [31:0] data;
   } rexp_t;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        m0_req_i = 1'b0, m0_we_i = 1'b0;
   logic [3:0]  m0_be_i = '0;
   logic [31:0] m0_addr_i = '0, m0_wdata_i = '0;
   logic        m1_req_i = 1'b0, m1_we_i = 1'b0, m1_lock_i = 1'b0;
   logic [3:0]  m1_be_i = '0;
   logic [31:0] m1_addr_i = '0, m1_wdata_i = '0;
   logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
   logic [31:0] m0_rdata_o, m1_rdata_o;
   logic        s_req_o, s_we_o;
   logic [3:0]  s_be_o;
   logic [31:0] s_addr_o, s_wdata_o;
   logic [31:0] s_rdata_i = 32'h1234_5678;

   int    cyc = 0;
   int    n_cmp = 0;
   int    n_err = 0;
   gexp_t q_g[$];
   rexp_t q_r[$];

   localparam stim_t NONE = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_arbiter #(.MAX_LOCK(4), .ADDR_W(32)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
      .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
      .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
      .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
      .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
      .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
      .m1_lock_i(m1_lock_i),
      .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
      .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata_i)
   );

   // Slave model: data content is a fixed function of the address.
   function automatic logic [31:0] sdata(input logic [31:0] a);
      return (a == 32'h8000_0010) ? 32'hDEAD_BEEF : (~a ^ 32'h0F0F_0F0F);
   endfunction

   always @(posedge clk) if (s_req_o) s_rdata_i <= sdata(s_addr_o);

   function automatic stim_t rd(input logic [31:0] a);
      return '{req: 1'b1, we: 1'b0, be: 4'hF, addr: a, wdata: 32'h0};
   endfunction

   function automatic stim_t wr(input logic [31:0] a, input logic [3:0] be,
                                input logic [31:0] d);
      return '{req: 1'b1, we: 1'b1, be: be, addr: a, wdata: d};
   endfunction

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // exp: 0 = m0 granted, 1 = m1 granted, -1 = no grant; rsp=0 when the
   // response is expected to be discarded by a following reset.
   task automatic step(input stim_t a, input stim_t b, input logic lk,
                       input logic rst, input int exp, input bit rsp);
      @(posedge clk); #1;
      rst_i = rst;
      m0_req_i = a.req; m0_we_i = a.we; m0_be_i = a.be;
      m0_addr_i = a.addr; m0_wdata_i = a.wdata;
      m1_req_i = b.req; m1_we_i = b.we; m1_be_i = b.be;
      m1_addr_i = b.addr; m1_wdata_i = b.wdata;
      m1_lock_i = lk;
      if (exp == 0) begin
         q_g.push_back('{cyc: cyc, id: 1'b0, s: a});
         if (rsp) q_r.push_back('{cyc: cyc + 1, id: 1'b0, data: sdata(a.addr)});
      end else if (exp == 1) begin
         q_g.push_back('{cyc: cyc, id: 1'b1, s: b});
         if (rsp) q_r.push_back('{cyc: cyc + 1, id: 1'b1, data: sdata(b.addr)});
      end
   endtask

   always @(negedge clk) begin : monitor
      gexp_t ge;
      rexp_t re;
      chk("gnt_onehot", {127'b0, m0_gnt_o & m1_gnt_o}, '0);
      if (m0_gnt_o || m1_gnt_o) begin
         if (q_g.size() == 0) begin
            chk("unexpected_grant", {126'b0, m1_gnt_o, m0_gnt_o}, '0);
         end else begin
            ge = q_g.pop_front();
            chk("grant",
                {cyc, m1_gnt_o, s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o},
                {ge.cyc, ge.id, 1'b1, ge.s.we, ge.s.be, ge.s.addr, ge.s.wdata});
         end
      end
      if (m0_rvalid_o || m1_rvalid_o) begin
         if (q_r.size() == 0) begin
            chk("unexpected_rvalid", {126'b0, m1_rvalid_o, m0_rvalid_o}, '0);
         end else begin
            re = q_r.pop_front();
            chk("response",
                {cyc, m1_rvalid_o, m0_rvalid_o, m0_rdata_o, m1_rdata_o},
                {re.cyc, re.id, ~re.id, re.id ? 32'h0 : re.data,
                 re.id ? re.data : 32'h0});
         end
      end
      if (!m0_rvalid_o) chk("m0_rdata_idle", {96'b0, m0_rdata_o}, '0);
      if (!m1_rvalid_o) chk("m1_rdata_idle", {96'b0, m1_rdata_o}, '0);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int e;
`ifdef MEM_ARBITER_RR_EN
      bit rr = 1'b1;
`else
      bit rr = 1'b0;
`endif
      // Reset with both masters requesting: no grants, quiet outputs.
      step(rd(32'h10), rd(32'h20), 1'b1, 1'b1, -1, 1'b0);
      step(rd(32'h10), rd(32'h20), 1'b1, 1'b1, -1, 1'b0);
      @(negedge clk);
      chk("reset_outputs", {m0_gnt_o, m1_gnt_o, s_req_o, m0_rvalid_o,
                            m1_rvalid_o, m0_rdata_o, m1_rdata_o}, '0);
      step(NONE, NONE, 1'b0, 1'b0, -1, 1'b0);

      // Single m0 read, single m0 write, single m1 read.
      step(rd(32'h8000_0010), NONE, 1'b0, 1'b0, 0, 1'b1);
      step(wr(32'h0000_0100, 4'b0011, 32'hCAFE_0011), NONE, 1'b0, 1'b0, 0, 1'b1);
      step(NONE, rd(32'h0000_0200), 1'b0, 1'b0, 1, 1'b1);

      // Continuous contention without lock.
      for (int i = 0; i < 4; i++) begin
         e = rr ? (i % 2) : 0;
         step(rd(32'h1000 + 32'(i) * 4),
              wr(32'h2000 + 32'(i) * 4, 4'hF, 32'hA000_0000 + 32'(i)),
              1'b0, 1'b0, e, 1'b1);
      end

      // Lock held: IDLE grant, four LOCK grants, COOL grants m0, then normal.
      step(NONE, rd(32'h3000), 1'b1, 1'b0, 1, 1'b1);
      for (int i = 0; i < 4; i++)
         step(rd(32'h3100), rd(32'h3200 + 32'(i) * 4), 1'b1, 1'b0, 1, 1'b1);
      step(rd(32'h3300), rd(32'h3400), 1'b1, 1'b0, 0, 1'b1);
      step(rd(32'h3500), rd(32'h3600), 1'b0, 1'b0, rr ? 1 : 0, 1'b1);

      // Lock dropped after two LOCK cycles: m0 wins the next cycle.
      step(NONE, rd(32'h4000), 1'b1, 1'b0, 1, 1'b1);
      step(rd(32'h4100), rd(32'h4200), 1'b1, 1'b0, 1, 1'b1);
      step(rd(32'h4100), rd(32'h4204), 1'b1, 1'b0, 1, 1'b1);
      step(rd(32'h4100), rd(32'h4208), 1'b0, 1'b0, 1, 1'b1);
      step(rd(32'h4100), rd(32'h420C), 1'b0, 1'b0, 0, 1'b1);

      // Reset in the cycle after an m1 lock grant discards its response.
      step(NONE, rd(32'h5000), 1'b1, 1'b0, 1, 1'b0);
      step(rd(32'h5100), rd(32'h5200), 1'b1, 1'b1, -1, 1'b0);
      @(negedge clk);
      chk("reset_discard", {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o,
                            m1_rdata_o}, '0);
      step(NONE, NONE, 1'b0, 1'b0, -1, 1'b0);
      @(negedge clk);
      chk("post_reset_quiet", {s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o,
                               m0_rvalid_o, m1_rvalid_o, m0_rdata_o,
                               m1_rdata_o}, '0);
      step(rd(32'h5300), rd(32'h5400), 1'b1, 1'b0, 0, 1'b1);
      step(NONE, rd(32'h5500), 1'b0, 1'b0, 1, 1'b1);

      for (int i = 0; i < 3; i++) step(NONE, NONE, 1'b0, 1'b0, -1, 1'b0);
      chk("grant_queue_drained", 128'(q_g.size()), '0);
      chk("rsp_queue_drained", 128'(q_r.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
